// File: rtl/mem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port indices
// and the func3 access-size codes used by the data memory and load/store unit.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic PORT_MEM = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port not
// served last. The last-served pointer only moves when upd_i is asserted.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    input  logic       served_i,
    output logic       gnt_o
);

    // Resetting to PORT_AUX makes the first tie go to PORT_MEM.
    logic last_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= PORT_AUX;
        end else if (upd_i) begin
            last_q <= served_i;
        end
    end

    always_comb begin
        gnt_o = PORT_MEM;
        if (req_i == 2'b11) begin
            gnt_o = ~last_q;
        end else if (req_i[1]) begin
            gnt_o = PORT_AUX;
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares one strobe/busywait data-memory port between the MEM stage and an aux
// requester: latch winner, one-cycle strobe, wait out busywait (with timeout).
module data_memory_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        P0_Read,
    input  logic        P0_Write,
    input  logic [31:0] P0_Address,
    input  logic [31:0] P0_Write_data,
    input  logic [2:0]  P0_Func3,
    output logic [31:0] P0_Read_data,
    output logic        P0_busywait,
    input  logic        P1_Read,
    input  logic        P1_Write,
    input  logic [31:0] P1_Address,
    input  logic [31:0] P1_Write_data,
    input  logic [2:0]  P1_Func3,
    output logic [31:0] P1_Read_data,
    output logic        P1_busywait,
    output logic        Mem_Read,
    output logic        Mem_Write,
    output logic [31:0] Mem_Address,
    output logic [31:0] Mem_Write_data,
    output logic [2:0]  Mem_Func3,
    input  logic [31:0] Mem_Read_data,
    input  logic        Mem_busywait,
    output logic        Grant,
    output logic        Error
);

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t      state_q;
    logic        rd_q, wr_q, is_wr_q, grant_q, err_q, seen_q;
    logic [31:0] addr_q, wdata_q, rdata0_q, rdata1_q;
    logic [2:0]  f3_q;
    logic [7:0]  cnt_q, cnt_d;

    logic [1:0]  req;
    logic        gnt, win_wr, wait_ok, wait_tmo, ptr_upd;
    logic [31:0] win_addr, win_wdata;
    logic [2:0]  win_f3;

    assign req       = {P1_Read | P1_Write, P0_Read | P0_Write};
    assign win_wr    = gnt ? P1_Write      : P0_Write;
    assign win_addr  = gnt ? P1_Address    : P0_Address;
    assign win_wdata = gnt ? P1_Write_data : P0_Write_data;
    assign win_f3    = gnt ? P1_Func3      : P0_Func3;

    // Normal completion takes priority over a timeout landing in the same cycle.
    assign cnt_d    = cnt_q + 8'd1;
    assign wait_ok  = (state_q == S_WAIT) && !Mem_busywait && seen_q;
    assign wait_tmo = (state_q == S_WAIT) && !wait_ok && (cnt_d == TMO);
    assign ptr_upd  = wait_ok || wait_tmo;

    rr_arbiter2 u_arb (
        .clk_i    (Clock),
        .rst_i    (Reset),
        .req_i    (req),
        .upd_i    (ptr_upd),
        .served_i (grant_q),
        .gnt_o    (gnt)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            is_wr_q  <= 1'b0;
            grant_q  <= PORT_MEM;
            err_q    <= 1'b0;
            seen_q   <= 1'b0;
            cnt_q    <= 8'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            f3_q     <= 3'd0;
            rdata0_q <= 32'd0;
            rdata1_q <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|req) begin
                        addr_q  <= win_addr;
                        wdata_q <= win_wdata;
                        f3_q    <= win_f3;
                        is_wr_q <= win_wr;
                        wr_q    <= win_wr;
                        rd_q    <= ~win_wr;
                        grant_q <= gnt;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                    seen_q  <= 1'b0;
                    cnt_q   <= 8'd0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    cnt_q <= cnt_d;
                    if (Mem_busywait) begin
                        seen_q <= 1'b1;
                        if (!is_wr_q) begin
                            if (grant_q) rdata1_q <= Mem_Read_data;
                            else         rdata0_q <= Mem_Read_data;
                        end
                    end
                    if (wait_ok) begin
                        state_q <= S_DONE;
                    end else if (wait_tmo) begin
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                        if (!is_wr_q) begin
                            if (grant_q) rdata1_q <= 32'd0;
                            else         rdata0_q <= 32'd0;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign P0_busywait    = req[0] & ~((state_q == S_DONE) && (grant_q == PORT_MEM));
    assign P1_busywait    = req[1] & ~((state_q == S_DONE) && (grant_q == PORT_AUX));
    assign P0_Read_data   = rdata0_q;
    assign P1_Read_data   = rdata1_q;
    assign Mem_Read       = rd_q;
    assign Mem_Write      = wr_q;
    assign Mem_Address    = addr_q;
    assign Mem_Write_data = wdata_q;
    assign Mem_Func3      = f3_q;
    assign Grant          = grant_q;
    assign Error          = err_q;

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Two-port arbiter and sequencer for the data memory: it shares one `Data_Memory`-style port (one-cycle `Read`/`Write` strobe, `busywait` reply) between the pipeline MEM stage (port 0) and a second requester (port 1: instruction-fetch refill or debug loader). It latches the winning request, issues a single-cycle strobe, waits out the memory's `busywait`, and returns registered load data. It sits between the MEM/port-1 stall logic and the data memory instance in the CPU top level.

## Interface
- `TIMEOUT`, default 64: maximum cycles in WAIT before an abort; range 2..255.
- `Clock` in 1: single clock, rising edge.
- `Reset` in 1: synchronous, active-high.
- `P0_Read`, `P0_Write` in 1 each: port 0 (MEM stage) request. If both are high, the request is treated as a write.
- `P0_Address` in 32, `P0_Write_data` in 32, `P0_Func3` in 3: port 0 request fields.
- `P0_Read_data` out 32: registered load result for port 0.
- `P0_busywait` out 1: stall for port 0.
- `P1_*`: the same seven signals for port 1.
- `Mem_Read`, `Mem_Write` out 1 each: strobes to the data memory.
- `Mem_Address` out 32, `Mem_Write_data` out 32, `Mem_Func3` out 3: latched request fields.
- `Mem_Read_data` in 32, `Mem_busywait` in 1: replies from the data memory.
- `Grant` out 1: index of the port latched or in service.
- `Error` out 1: sticky flag, set on timeout.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - If any request is present, choose a winner.
  - Latch the winner's address, write data, func3 and read/write type into the `Mem_*` registers. Register `Grant`. Go to ISSUE.
- **Arbitration**: round-robin with a last-served pointer.
  - If only one port requests, it wins.
  - If both request, the port not served last wins.
  - After reset the pointer favours port 0.
  - The pointer updates only on entry to DONE.
- **ISSUE**: drive `Mem_Read` or `Mem_Write` high for exactly this one cycle, then go to WAIT.
- **WAIT**
  - Strobes are low.
  - A `seen` flag sets on the first cycle `Mem_busywait`=1.
  - Every cycle with `Mem_busywait`=1 and a read in service, capture `Mem_Read_data` into the granted port's result register. The last capture wins.
  - `Mem_busywait`=0 with `seen`=1 means go to DONE.
  - The timeout counter increments each WAIT cycle. When it reaches `TIMEOUT`: set `Error`, write 0 into the granted read result, go to DONE.
- **DONE**: one cycle, then IDLE.
- **Stall rule (combinational)**: `Px_busywait` = (`Px_Read` | `Px_Write`) & !(state==DONE & `Grant`==x).
  - A requester stalls from the first cycle it asserts a request.
  - It is released only in the DONE cycle of its own transaction.
- `Px_Read_data` holds its value until the next completed read for that port. Writes do not change it.
- A request that arrives, or changes, while another transaction is in service is ignored until the next IDLE. Latched fields never change mid-transaction.
- A request dropped before service never reaches the memory.
- Reset mid-transaction:
  - Next state is IDLE.
  - `Mem_Read`/`Mem_Write` are 0 from that edge.
  - `seen`, counter and pointer clear.
  - Any in-flight result is discarded.

## Timing
- Reset values:
  - FSM: IDLE.
  - `Mem_Read`, `Mem_Write`: 0.
  - `Mem_Address`, `Mem_Write_data`: 0.
  - `Mem_Func3`: 0.
  - `P0_Read_data`, `P1_Read_data`: 0.
  - `Grant`: 0.
  - `Error`: 0.
  - Counter: 0.
  - `Px_busywait` follows its combinational rule (0 with no request).
- Latency with a memory that holds `busywait` high for exactly one cycle (request first present in cycle 0 while IDLE):
  - Cycle 1: ISSUE, strobe high.
  - Cycle 2: WAIT, `Mem_busywait`=1, data captured.
  - Cycle 3: WAIT, `Mem_busywait`=0.
  - Cycle 4: DONE, `Px_busywait`=0, data valid.
  - The requester advances at the end of cycle 4.
- Each extra cycle of `Mem_busywait` adds one cycle of latency.
- Minimum request-to-request spacing is 5 cycles, because DONE is followed by one IDLE cycle.
- `Error` clears only on `Reset`.

## Structure
- Shared package `mem_arb_pkg` holds:
  - FSM state encoding (2 bits).
  - Port index constants `PORT_MEM`=0 and `PORT_AUX`=1.
  - Func3 constants LB/LH/LW/LBU/LHU/SB/SH/SW, shared with the data memory and the load/store unit.
- One sub-module, `rr_arbiter2`: combinational pick from two request bits and the pointer, plus the pointer register with an update enable.

## Test plan
- **Port 0 LW at 0x10**, memory returns 0xDEADBEEF with a one-cycle `busywait` → `Mem_Read` high only in cycle 1; `P0_busywait` 1 in cycles 0–3 and 0 in cycle 4; `P0_Read_data`=0xDEADBEEF in cycle 4.
- **Both ports read in the same cycle after reset** → port 0 is served first (`Grant`=0). Port 1 ISSUE occurs in cycle 6. `P1_busywait` stays high until that transaction's DONE in cycle 9.
- **Port 1 SW of 0x12345678 to 0x20, then port 0 SB of 0xAA to 0x21** → `Mem_Write`/`Mem_Address`/`Mem_Func3` show 0x20/010, then 0x21/000. `P0_Read_data` and `P1_Read_data` are unchanged.
- **Memory holds `busywait` low forever after ISSUE, `TIMEOUT`=8** → DONE after 8 WAIT cycles; `Error`=1; read result 0; the next request is still served normally.
- **`Reset` asserted in the WAIT cycle of a port 0 read** → next cycle: IDLE, strobes 0, `Error`=0, `P0_Read_data`=0. A held request re-arbitrates and issues one cycle after reset is released.
